// File: rtl/cpu_if_pkg.sv
// rtl/cpu_if_pkg.sv - shared CPU_IF bus widths, arbiter state encoding and defaults
package cpu_if_pkg;

  localparam int CPU_IF_DATA_W = 32;
  localparam int CPU_IF_ADDR_W = 30;

  localparam logic [CPU_IF_DATA_W-1:0] CPU_IF_ERR_READ_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } cpu_if_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_if_arbiter_if.sv
// rtl/cpu_if_arbiter_if.sv - upstream master and downstream slave CPU_IF signals
interface cpu_if_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  import cpu_if_pkg::*;

  logic [NUM_MASTERS-1:0]               m_cpu_if_read;
  logic [NUM_MASTERS-1:0]               m_cpu_if_write;
  logic [NUM_MASTERS*CPU_IF_DATA_W-1:0] m_cpu_if_write_data;
  logic [NUM_MASTERS*CPU_IF_ADDR_W-1:0] m_cpu_if_address;
  logic [NUM_MASTERS*CPU_IF_DATA_W-1:0] m_cpu_if_read_data;
  logic [NUM_MASTERS-1:0]               m_cpu_if_access_complete;
  logic [NUM_MASTERS-1:0]               m_cpu_if_error;

  logic                     s_cpu_if_read;
  logic                     s_cpu_if_write;
  logic [CPU_IF_DATA_W-1:0] s_cpu_if_write_data;
  logic [CPU_IF_ADDR_W-1:0] s_cpu_if_address;
  logic [CPU_IF_DATA_W-1:0] s_cpu_if_read_data;
  logic                     s_cpu_if_access_complete;

  // slave: the arbiter's view; master: the surrounding masters and register file
  modport slave (
    input  m_cpu_if_read, m_cpu_if_write, m_cpu_if_write_data, m_cpu_if_address,
    output m_cpu_if_read_data, m_cpu_if_access_complete, m_cpu_if_error,
    output s_cpu_if_read, s_cpu_if_write, s_cpu_if_write_data, s_cpu_if_address,
    input  s_cpu_if_read_data, s_cpu_if_access_complete
  );

  modport master (
    output m_cpu_if_read, m_cpu_if_write, m_cpu_if_write_data, m_cpu_if_address,
    input  m_cpu_if_read_data, m_cpu_if_access_complete, m_cpu_if_error,
    input  s_cpu_if_read, s_cpu_if_write, s_cpu_if_write_data, s_cpu_if_address,
    output s_cpu_if_read_data, s_cpu_if_access_complete
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module rr_arbiter
  import cpu_if_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/cpu_if_arbiter.sv
// rtl/cpu_if_arbiter.sv - N-master to one-slave CPU_IF arbiter with per-access timeout
module cpu_if_arbiter
  import cpu_if_pkg::*;
#(
  parameter int                        NUM_MASTERS    = 2,
  parameter int                        TIMEOUT_CYCLES = 1024,
  parameter logic [CPU_IF_DATA_W-1:0]  ERR_READ_DATA  = CPU_IF_ERR_READ_DATA
) (
  input logic             clk,
  input logic             reset,
  cpu_if_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_MASTERS);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_MASTERS - 1);

  cpu_if_state_e state;

  logic [NUM_MASTERS-1:0] pending, op_write, busy, accept, grant_clear, arb_grant;
  logic [IDX_W-1:0]       rr_ptr, grant_idx, arb_idx;
  logic                   grant_write, expired;
  logic [CNT_W-1:0]       tmo_cnt;

  logic [NUM_MASTERS-1:0][CPU_IF_ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS-1:0][CPU_IF_DATA_W-1:0] m_wdata, rdata_q;
  logic [NUM_MASTERS-1:0]                    complete_q, error_q;

  logic                     s_read_q, s_write_q;
  logic [CPU_IF_ADDR_W-1:0] s_addr_q;
  logic [CPU_IF_DATA_W-1:0] s_wdata_q;

  assign m_addr  = bus.m_cpu_if_address;
  assign m_wdata = bus.m_cpu_if_write_data;

  assign bus.m_cpu_if_read_data       = rdata_q;
  assign bus.m_cpu_if_access_complete = complete_q;
  assign bus.m_cpu_if_error           = error_q;
  assign bus.s_cpu_if_read            = s_read_q;
  assign bus.s_cpu_if_write           = s_write_q;
  assign bus.s_cpu_if_address         = s_addr_q;
  assign bus.s_cpu_if_write_data      = s_wdata_q;

  rr_arbiter #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (pending),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .index (arb_idx)
  );

  // The granted master stays busy from grant until its RESP cycle ends.
  always_comb begin
    busy = '0;
    if (state != ST_IDLE) busy[grant_idx] = 1'b1;
  end

  assign accept      = (bus.m_cpu_if_read | bus.m_cpu_if_write) & ~pending & ~busy;
  assign grant_clear = (state == ST_IDLE) ? arb_grant : '0;
  // Counter saturates at TIMEOUT_CYCLES, which is reached on the expiry cycle.
  assign expired     = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pending     <= '0;
      op_write    <= '0;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      grant_write <= 1'b0;
      tmo_cnt     <= '0;
      rdata_q     <= '0;
      complete_q  <= '0;
      error_q     <= '0;
      s_read_q    <= 1'b0;
      s_write_q   <= 1'b0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
    end else begin
      s_read_q   <= 1'b0;
      s_write_q  <= 1'b0;
      complete_q <= '0;
      error_q    <= '0;
      pending    <= (pending & ~grant_clear) | accept;
      op_write   <= (op_write & ~accept) | (bus.m_cpu_if_write & accept);

      case (state)
        ST_IDLE: begin
          if (|pending) begin
            grant_idx   <= arb_idx;
            grant_write <= op_write[arb_idx];
            s_read_q    <= ~op_write[arb_idx];
            s_write_q   <= op_write[arb_idx];
            s_addr_q    <= m_addr[arb_idx];
            s_wdata_q   <= m_wdata[arb_idx];
            rr_ptr      <= (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (TIMEOUT_CYCLES != 0 && tmo_cnt != TMO_LIMIT) tmo_cnt <= tmo_cnt + 1'b1;
          if (bus.s_cpu_if_access_complete) begin
            complete_q[grant_idx] <= 1'b1;
            if (!grant_write) rdata_q[grant_idx] <= bus.s_cpu_if_read_data;
            state <= ST_RESP;
          end else if (expired) begin
            complete_q[grant_idx] <= 1'b1;
            error_q[grant_idx]    <= 1'b1;
            if (!grant_write) rdata_q[grant_idx] <= ERR_READ_DATA;
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          tmo_cnt <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_if_arbiter.sv
// tb/tb_cpu_if_arbiter.sv - directed vector bench for cpu_if_arbiter with N=2, timeout 16
module tb_cpu_if_arbiter;
  import cpu_if_pkg::*;

  localparam int N   = 2;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_if_arbiter_if #(.NUM_MASTERS(N)) bus ();

  cpu_if_arbiter #(
    .NUM_MASTERS    (N),
    .TIMEOUT_CYCLES (TMO),
    .ERR_READ_DATA  (32'hDEAD_BEEF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          m;
    bit          wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    int          delay;    // slave complete this many cycles after its strobe; -1 = silent
    logic [31:0] sdata;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs[7];
  vec_t        post_rst;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_rd[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_of(input int m);
    return bus.m_cpu_if_read_data[32*m +: 32];
  endfunction

  task automatic set_req(input int m, input logic [29:0] addr, input logic [31:0] wdata);
    bus.m_cpu_if_address[30*m +: 30]    = addr;
    bus.m_cpu_if_write_data[32*m +: 32] = wdata;
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.s_cpu_if_read || bus.s_cpu_if_write) ok = 1'b1;
    end
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    set_req(v.m, v.addr, v.wdata);
    @(negedge clk);
    bus.m_cpu_if_read[v.m]  = ~v.wr;
    bus.m_cpu_if_write[v.m] = v.wr;
    @(negedge clk);
    bus.m_cpu_if_read  = '0;
    bus.m_cpu_if_write = '0;
    @(negedge clk);
    check({tag, " s_read"},  bus.s_cpu_if_read,  !v.wr);
    check({tag, " s_write"}, bus.s_cpu_if_write, v.wr);
    check({tag, " s_addr"},  bus.s_cpu_if_address, v.addr);
    if (v.wr) check({tag, " s_wdata"}, bus.s_cpu_if_write_data, v.wdata);
    if (v.delay >= 0) begin
      repeat (v.delay) @(negedge clk);
      bus.s_cpu_if_access_complete = 1'b1;
      bus.s_cpu_if_read_data       = v.sdata;
      check({tag, " early complete"}, bus.m_cpu_if_access_complete, '0);
      @(negedge clk);
      bus.s_cpu_if_access_complete = 1'b0;
      bus.s_cpu_if_read_data       = '0;
    end else begin
      repeat (TMO) @(negedge clk);
      check({tag, " early timeout"}, bus.m_cpu_if_access_complete, '0);
      @(negedge clk);
    end
    check({tag, " complete"}, bus.m_cpu_if_access_complete, 2'b01 << v.m);
    check({tag, " error"},    bus.m_cpu_if_error, v.exp_err ? (2'b01 << v.m) : 2'b00);
    check({tag, " rdata"},    rd_of(v.m), v.exp_rd);
    check({tag, " other rdata"}, rd_of(1 - v.m), model_rd[1 - v.m]);
    model_rd[v.m] = v.exp_rd;
    @(negedge clk);
    check({tag, " complete pulse"}, bus.m_cpu_if_access_complete, '0);
  endtask

  task automatic pair_write(input int round);
    bit ok;
    set_req(0, 30'h100 + 30'(round), 32'hA000_0000 + 32'(round));
    set_req(1, 30'h200 + 30'(round), 32'hB000_0000 + 32'(round));
    @(negedge clk);
    bus.m_cpu_if_write = 2'b11;
    @(negedge clk);
    bus.m_cpu_if_write = 2'b00;
    for (int k = 0; k < 2; k++) begin
      wait_strobe(ok);
      check($sformatf("pair%0d.%0d strobe seen", round, k), ok, 1'b1);
      check($sformatf("pair%0d.%0d s_write", round, k), bus.s_cpu_if_write, 1'b1);
      check($sformatf("pair%0d.%0d s_addr", round, k), bus.s_cpu_if_address,
            (k == 0 ? 30'h100 : 30'h200) + 30'(round));
      bus.s_cpu_if_access_complete = 1'b1;
      @(negedge clk);
      bus.s_cpu_if_access_complete = 1'b0;
      check($sformatf("pair%0d.%0d complete", round, k), bus.m_cpu_if_access_complete, 2'b01 << k);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish expected finish within 50000 ns");
    $fatal(1);
  end

  initial begin
    int cnt;
    vecs[0] = '{0, 1'b0, 30'h10,       32'h0,         3,  32'h1234_5678, 1'b0, 32'h1234_5678};
    vecs[1] = '{1, 1'b1, 30'h2A,       32'hCAFE_0001, 0,  32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[2] = '{1, 1'b0, 30'h3,        32'h0,         -1, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{1, 1'b0, 30'h5,        32'h0,         2,  32'hA5A5_0001, 1'b0, 32'hA5A5_0001};
    vecs[4] = '{0, 1'b0, 30'h7,        32'h0,         16, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D};
    vecs[5] = '{0, 1'b1, 30'h8,        32'h0000_1234, -1, 32'h0,         1'b1, 32'h0BAD_F00D};
    vecs[6] = '{1, 1'b0, 30'h3FFF_FFFF, 32'h0,        15, 32'h1111_2222, 1'b0, 32'h1111_2222};
    post_rst = '{1, 1'b0, 30'h55,      32'h0,         1,  32'h600D_600D, 1'b0, 32'h600D_600D};
    for (int i = 0; i < N; i++) model_rd[i] = '0;

    reset = 1'b1;
    bus.m_cpu_if_read = '0;
    bus.m_cpu_if_write = '0;
    bus.m_cpu_if_write_data = '0;
    bus.m_cpu_if_address = '0;
    bus.s_cpu_if_read_data = '0;
    bus.s_cpu_if_access_complete = 1'b0;
    repeat (3) @(negedge clk);
    check("reset s_read",   bus.s_cpu_if_read, 1'b0);
    check("reset s_write",  bus.s_cpu_if_write, 1'b0);
    check("reset s_addr",   bus.s_cpu_if_address, '0);
    check("reset s_wdata",  bus.s_cpu_if_write_data, '0);
    check("reset rdata",    bus.m_cpu_if_read_data, '0);
    check("reset complete", bus.m_cpu_if_access_complete, '0);
    check("reset error",    bus.m_cpu_if_error, '0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    pair_write(0);
    pair_write(1);

    // read and write together, then repeats while pending and while in flight
    set_req(0, 30'h77, 32'h7777_0000);
    @(negedge clk);
    bus.m_cpu_if_read[0] = 1'b1; bus.m_cpu_if_write[0] = 1'b1;
    @(negedge clk);
    bus.m_cpu_if_read[0] = 1'b0;
    @(negedge clk);
    bus.m_cpu_if_write[0] = 1'b0;
    check("rw s_write", bus.s_cpu_if_write, 1'b1);
    check("rw s_read",  bus.s_cpu_if_read,  1'b0);
    check("rw s_wdata", bus.s_cpu_if_write_data, 32'h7777_0000);
    @(negedge clk);
    bus.m_cpu_if_write[0] = 1'b1;
    @(negedge clk);
    bus.m_cpu_if_write[0] = 1'b0;
    bus.s_cpu_if_access_complete = 1'b1;
    @(negedge clk);
    bus.s_cpu_if_access_complete = 1'b0;
    check("rw complete", bus.m_cpu_if_access_complete, 2'b01);
    check("rw rdata kept", rd_of(0), model_rd[0]);
    cnt = 0;
    repeat (24) begin
      @(negedge clk);
      if (bus.s_cpu_if_read || bus.s_cpu_if_write) cnt++;
    end
    check("repeat strobe accesses", 32'(cnt), 32'd0);

    // slave complete while idle
    bus.s_cpu_if_access_complete = 1'b1;
    bus.s_cpu_if_read_data = 32'h5555_AAAA;
    @(negedge clk);
    bus.s_cpu_if_access_complete = 1'b0;
    bus.s_cpu_if_read_data = '0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.m_cpu_if_access_complete != '0 || bus.m_cpu_if_error != '0) cnt++;
    end
    check("idle complete responses", 32'(cnt), 32'd0);
    check("idle complete rdata", bus.m_cpu_if_read_data, {model_rd[1], model_rd[0]});

    // reset during WAIT
    set_req(1, 30'h55, 32'h0);
    @(negedge clk);
    bus.m_cpu_if_read[1] = 1'b1;
    @(negedge clk);
    bus.m_cpu_if_read[1] = 1'b0;
    @(negedge clk);
    check("rst s_read before", bus.s_cpu_if_read, 1'b1);
    check("rst s_addr before", bus.s_cpu_if_address, 30'h55);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst async s_addr",   bus.s_cpu_if_address, '0);
    check("rst async s_wdata",  bus.s_cpu_if_write_data, '0);
    check("rst async rdata",    bus.m_cpu_if_read_data, '0);
    check("rst async complete", bus.m_cpu_if_access_complete, '0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) model_rd[i] = '0;
    cnt = 0;
    repeat (24) begin
      @(negedge clk);
      if (bus.m_cpu_if_access_complete != '0 || bus.s_cpu_if_read || bus.s_cpu_if_write) cnt++;
    end
    check("rst aborted activity", 32'(cnt), 32'd0);
    run_txn("post_rst", post_rst);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
